// File: rtl/sfc_pkg.sv
// Shared definitions for the serial frame collector.
// Holds the default frame width and the output buffer state encoding.
package sfc_pkg;

    localparam int SFC_WIDTH = 7;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } sfc_buf_state_e;

endpackage

// File: rtl/sfc_shift_core.sv
// Serial-to-parallel core: bit counter, shift register, frame_start.
// Ports: clk, reset (sync, active-high), bit_valid_i, bit_in_i,
//        frame_start_i, done_o (completion this cycle), frame_o (word).
import sfc_pkg::*;

module sfc_shift_core #(
    parameter int WIDTH = SFC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid_i,
    input  logic             bit_in_i,
    input  logic             frame_start_i,
    output logic             done_o,
    output logic [WIDTH-1:0] frame_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
    logic [WIDTH-1:0] sh_q, sh_d, word;

    // done_o/frame_o are combinational so the registered buffer
    // in the top presents the frame one cycle after the last bit.
    always_comb begin
        base_cnt = frame_start_i ? '0 : cnt_q;
        word     = frame_start_i ? '0 : sh_q;
        done_o   = 1'b0;
        cnt_d    = base_cnt;
        sh_d     = word;
        if (bit_valid_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (base_cnt == CNT_W'(i)) begin
                    word[i] = bit_in_i;
                end
            end
            done_o = (base_cnt == CNT_W'(WIDTH - 1));
            if (done_o) begin
                cnt_d = '0;
                sh_d  = '0;
            end else begin
                cnt_d = base_cnt + CNT_W'(1);
                sh_d  = word;
            end
        end
    end

    assign frame_o = word;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/serial_frame_collector.sv
// Serial frame collector: assembles LSB-first frames and offers them
// through a one-entry valid/ready buffer with a sticky overrun flag.
// Ports: clk, reset, bit_valid, bit_in, frame_start, out_valid,
//        out_ready, out_data[WIDTH], overrun; frame_cnt[16] only when
//        SERIAL_FRAME_COLLECTOR_FRAME_CNT_EN is defined.
import sfc_pkg::*;

module serial_frame_collector #(
    parameter int WIDTH = SFC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             frame_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overrun
`ifdef SERIAL_FRAME_COLLECTOR_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    logic             done;
    logic [WIDTH-1:0] frame;

    sfc_buf_state_e   state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             overrun_q;
`ifdef SERIAL_FRAME_COLLECTOR_FRAME_CNT_EN
    logic [15:0]      frame_cnt_q;
`endif

    sfc_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk           (clk),
        .reset         (reset),
        .bit_valid_i   (bit_valid),
        .bit_in_i      (bit_in),
        .frame_start_i (frame_start),
        .done_o        (done),
        .frame_o       (frame)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
`ifdef SERIAL_FRAME_COLLECTOR_FRAME_CNT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (done) begin
                        out_data_q  <= frame;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
`ifdef SERIAL_FRAME_COLLECTOR_FRAME_CNT_EN
                        frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
                        // Same-cycle refill keeps the buffer full.
                        if (done) begin
                            out_data_q <= frame;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_EMPTY;
                        end
                    end else if (done) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overrun   = overrun_q;
`ifdef SERIAL_FRAME_COLLECTOR_FRAME_CNT_EN
    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_serial_frame_collector.sv
// Directed bench for serial_frame_collector with a queue-based model.
// Outputs are checked against the model every cycle, #1 after the edge.
module tb_serial_frame_collector;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         bit_valid;
    logic         bit_in;
    logic         frame_start;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         overrun;
`ifdef SERIAL_FRAME_COLLECTOR_FRAME_CNT_EN
    logic [15:0]  frame_cnt;
`endif

    always #5 clk = ~clk;

    serial_frame_collector #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .frame_start (frame_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .overrun     (overrun)
`ifdef SERIAL_FRAME_COLLECTOR_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    bit           cur[$];
    logic         m_valid = 1'b0;
    logic         m_ovr   = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_cnt   = 0;
    int           cycle   = 0;
    int           hs_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
                     nm, act, exp, cycle);
        end
    endtask

    task automatic cyc(input logic rst, input logic bv, input logic bi,
                       input logic fs, input logic rdy);
        logic         comp;
        logic         hs;
        logic [W-1:0] word;
        reset       = rst;
        bit_valid   = bv;
        bit_in      = bi;
        frame_start = fs;
        out_ready   = rdy;
        @(posedge clk);
        cycle++;
        comp = 1'b0;
        word = '0;
        if (rst) begin
            cur.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_data  = '0;
            m_cnt   = 0;
        end else begin
            if (fs) cur.delete();
            if (bv) begin
                cur.push_back(bi);
                if (cur.size() == W) begin
                    comp = 1'b1;
                    for (int i = 0; i < W; i++) word[i] = cur[i];
                    cur.delete();
                end
            end
            hs = m_valid && rdy;
            if (hs) begin
                m_cnt = (m_cnt + 1) % 65536;
                hs_cyc.push_back(cycle);
            end
            if (hs && comp) begin
                m_data = word;
            end else if (hs) begin
                m_valid = 1'b0;
            end else if (comp && !m_valid) begin
                m_valid = 1'b1;
                m_data  = word;
            end else if (comp) begin
                m_ovr = 1'b1;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (m_valid) chk("out_data", 32'(out_data), 32'(m_data));
`ifdef SERIAL_FRAME_COLLECTOR_FRAME_CNT_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic send(input logic [W-1:0] w, input logic rdy);
        for (int i = 0; i < W; i++) cyc(1'b0, 1'b1, w[i], 1'b0, rdy);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Bits 1,0,1,1,0,0,1 with ready high
        send(7'b1001101, 1'b1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h4D);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_one_cycle", 32'(out_valid), 32'd0);

        // Stall through two frames -> overrun
        do_reset();
        send(7'h7F, 1'b0);
        chk("t2_data1", 32'(out_data), 32'h7F);
        send(7'b1000000, 1'b0);
        chk("t2_data2", 32'(out_data), 32'h7F);
        chk("t2_ovr", 32'(overrun), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_ovr_sticky", 32'(overrun), 32'd1);

        // 21 continuous bits, ready high
        do_reset();
        hs_cyc.delete();
        send(7'b0110011, 1'b1);
        send(7'b1010101, 1'b1);
        send(7'b1110000, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_frames", 32'(hs_cyc.size()), 32'd3);
        if (hs_cyc.size() == 3) begin
            chk("t3_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd7);
            chk("t3_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd7);
        end
        chk("t3_ovr", 32'(overrun), 32'd0);
`ifdef SERIAL_FRAME_COLLECTOR_FRAME_CNT_EN
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd3);
`endif

        // Completion and handshake in the same cycle
        do_reset();
        a = 7'b0101010;
        b = 7'b1100110;
        send(a, 1'b0);
        for (int i = 0; i < W - 1; i++) cyc(1'b0, 1'b1, b[i], 1'b0, 1'b0);
        chk("t4_old", 32'(out_data), 32'h2A);
        cyc(1'b0, 1'b1, b[W-1], 1'b0, 1'b1);
        chk("t4_valid", 32'(out_valid), 32'd1);
        chk("t4_data", 32'(out_data), 32'h66);
        chk("t4_ovr", 32'(overrun), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // frame_start mid-frame with a bit in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_nopartial", 32'(out_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_data", 32'(out_data), 32'h01);

        // Reset mid-frame while a frame is buffered
        do_reset();
        send(7'b0011100, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_ovr", 32'(overrun), 32'd0);
        send(7'b0110101, 1'b0);
        chk("t6_fresh_valid", 32'(out_valid), 32'd1);
        chk("t6_fresh_data", 32'(out_data), 32'h35);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_frame_collector.md
Name: serial_frame_collector

Overview:
- Upstream feeder for the combinational 7-bit ones-counter stage.
- Collects a serial bit stream, LSB first, into WIDTH-bit frames.
- Hands each frame downstream through a one-entry output buffer with a valid/ready handshake.
- Flags frames lost because downstream stalled too long.

Parameters:
- WIDTH, 7, bits per frame; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_valid  input  1  bit_in is sampled this cycle.
- bit_in  input  1  serial data bit.
- frame_start  input  1  discard any partial frame and restart collection.
- out_valid  output  1  out_data holds a complete frame.
- out_ready  input  1  downstream accepts the frame this cycle.
- out_data  output  WIDTH  assembled frame; bit 0 is the first bit received.
- overrun  output  1  sticky: a completed frame was dropped.

Behaviour:
- Reset is synchronous, active-high, and overrides every other input in that cycle.
  - Reset values: out_valid=0, out_data=0, overrun=0, bit counter=0, shift register=0, buffer state EMPTY.
  - Reset mid-frame discards the partial frame and the buffered frame without signalling.
- Collection, per cycle with bit_valid=1:
  - bit_in is written to shift-register position cnt; cnt increments.
  - Bits arriving with bit_valid=0 are ignored.
  - No ready is returned to the serial side; it is always accepted.
- frame_start=1:
  - cnt is forced to 0 and the partial frame is discarded.
  - If bit_valid=1 in the same cycle, that bit becomes bit 0 of the new frame and cnt becomes 1.
  - Has no effect on the output buffer.
- Frame completion: a bit accepted with cnt==WIDTH-1.
  - The full WIDTH-bit word (including this bit) is offered to the output buffer.
  - cnt wraps to 0; back-to-back frames need no gap cycle.
- Output buffer FSM, two states:
  - EMPTY: out_valid=0. On completion, load out_data and go to FULL. out_valid is 1 on the cycle after the last bit (latency 1 cycle from last bit).
  - FULL: out_valid=1 and out_data stable until the handshake (out_valid & out_ready).
    - Handshake without completion: go to EMPTY. out_data keeps its last value and is don't-care for the bench.
    - Handshake with completion in the same cycle: load the new frame and stay FULL. No bubble, no overrun.
    - Completion without handshake: drop the new frame, set overrun=1, keep the old frame unchanged.
- overrun stays set until reset; nothing else clears it.
- out_ready while EMPTY is ignored.
- The output depends only on registers; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_FRAME_COLLECTOR_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt [15:0].
  - Increments once per handshake; wraps 16'hFFFF to 0.
  - Reset value 0.
  - Not incremented by dropped frames.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package sfc_pkg holds:
  - default frame width constant SFC_WIDTH=7;
  - buffer state encoding (ST_EMPTY=1'b0, ST_FULL=1'b1).
- One natural sub-module, sfc_shift_core: bit counter, shift register and frame_start handling. It emits a one-cycle done pulse with the frame.
- The top level holds the output buffer FSM, overrun and the optional counter.

Test Plan:
- Reset then 7 bits 1,0,1,1,0,0,1 with out_ready=1:
  - out_valid=1 for exactly one cycle, on the cycle after the 7th bit;
  - out_data=7'b1001101.
- Hold out_ready=0 through the first frame (1,1,1,1,1,1,1) and stream a second frame (0,0,0,0,0,0,1):
  - out_data stays 7'h7F;
  - overrun rises the cycle after the 14th bit and stays 1 after out_ready=1.
- Continuous 21 bits, out_ready=1 throughout:
  - three frames delivered, each exactly 7 cycles apart;
  - overrun=0.
- Completion and handshake in the same cycle:
  - out_valid remains 1 with no gap;
  - out_data switches to the new frame;
  - overrun=0.
- 4 bits, then frame_start with bit_valid=1 and bit_in=1, then 6 bits of 0:
  - out_data=7'b0000001;
  - the partial frame never appears.
- Assert reset after 5 bits of a frame while out_valid=1:
  - next cycle out_valid=0 and overrun=0;
  - a fresh 7 bits produce a correct frame.
- With the macro defined: frame_cnt=3 after the 21-bit run.
